// File: rtl/spislave.sv
// SPI slave, 8-bit frames, MSB first, runtime-selectable cpol/cpha/cspol.
// SPI pins are brought into the clkin domain through 2-flop synchronizers;
// all edge detection runs on the synchronized copies.
// Optional feature: define SPISLAVE_OVERRUN_EN to enable the pending/overrun
// tracking; without it overrun is tied low.
module spislave (
   input  logic       clkin,
   input  logic       rst,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       cspol,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       cs,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       busy,
   output logic       overrun
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t     state, state_nxt;
   logic       start;
   logic       sclk_s1, sclk_s2, sclk_d;
   logic       cs_s1, cs_s2;
   logic       mosi_s1, mosi_s2;
   logic [1:0] settle;
   logic       armed;
   logic [7:0] tx_buf, tx_sh, rx_sh;
   logic [2:0] cnt;

   logic       cs_act, sclk_edge, lead, trail, samp, shft, active_run;
   logic [7:0] reload_val;

   assign cs_act     = cs_s2 ^ cspol;
   assign sclk_edge  = sclk_s2 ^ sclk_d;
   assign lead       = sclk_edge & (sclk_s2 ^ cpol);
   assign trail      = sclk_edge & ~(sclk_s2 ^ cpol);
   assign samp       = cpha ? trail : lead;
   assign shft       = cpha ? lead : trail;
   assign active_run = (state == ACTIVE) && cs_act;
   // A tx_load landing on a frame-start reload wins over the old buffer.
   assign reload_val = tx_load ? tx_data : tx_buf;

   assign busy    = (state == ACTIVE);
   assign miso_oe = busy;
   assign miso    = busy & tx_sh[7];

   // Synchronizers plus an arming flag: after reset a frame only starts once
   // cs has been seen inactive, so a cs held active through reset is ignored.
   always_ff @(posedge clkin) begin
      if (rst) begin
         sclk_s1 <= cpol;
         sclk_s2 <= cpol;
         sclk_d  <= cpol;
         cs_s1   <= cspol;
         cs_s2   <= cspol;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
         settle  <= 2'b00;
         armed   <= 1'b0;
      end else begin
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
         cs_s1   <= cs;
         cs_s2   <= cs_s1;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
         settle  <= {settle[0], 1'b1};
         if (settle[1] && !cs_act) armed <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clkin) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; start marks the IDLE->ACTIVE cycle.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE:   if (armed && cs_act) begin
                    state_nxt = ACTIVE;
                    start     = 1'b1;
                 end
         ACTIVE: if (!cs_act) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shift datapath. The shift edge holds while cnt==0: that covers the
   // first cpha=1 leading edge and the edge right after a frame-end reload,
   // so bit 7 of every frame is presented for a full bit time.
   always_ff @(posedge clkin) begin
      if (rst) begin
         tx_buf   <= 8'h00;
         tx_sh    <= 8'h00;
         rx_sh    <= 8'h00;
         cnt      <= 3'd0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (tx_load) tx_buf <= tx_data;
         if (start) begin
            tx_sh <= reload_val;
            cnt   <= 3'd0;
         end else if (active_run) begin
            if (samp) begin
               rx_sh <= {rx_sh[6:0], mosi_s2};
               cnt   <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  rx_data  <= {rx_sh[6:0], mosi_s2};
                  rx_valid <= 1'b1;
                  tx_sh    <= reload_val;
               end
            end else if (shft && cnt != 3'd0) begin
               tx_sh <= {tx_sh[6:0], 1'b0};
            end
         end else if (state == ACTIVE) begin
            // cs dropped mid-frame: discard the partial frame.
            cnt <= 3'd0;
         end
      end
   end

`ifdef SPISLAVE_OVERRUN_EN
   logic pending;

   // Pending tracks an unacknowledged byte; a new byte on top of it is an overrun.
   always_ff @(posedge clkin) begin
      if (rst) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else if (rx_valid) begin
         pending <= 1'b1;
         if (pending) overrun <= 1'b1;
      end else if (rx_ack) begin
         pending <= 1'b0;
      end
   end
`else
   logic unused_ack;
   assign unused_ack = rx_ack;
   assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_spislave.sv
// Directed bench for spislave: mode 0 and mode 3 transfers, back-to-back
// frames, aborted frames, mid-frame reset, idle sclk and overrun flag.
module tb_spislave;

   logic       clkin = 1'b0;
   logic       rst, cpol, cpha, cspol, sclk, mosi, cs;
   logic       miso, miso_oe;
   logic [7:0] tx_data;
   logic       tx_load;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ack, busy, overrun;

   int         pass_cnt = 0;
   int         chk_cnt  = 0;
   int         vcnt     = 0;
   int         oe_cnt   = 0;
   int         lat;
   logic [7:0] rx_hist [0:15];
   logic [7:0] m1, m2;

`ifdef SPISLAVE_OVERRUN_EN
   localparam logic EXP_OVR = 1'b1;
`else
   localparam logic EXP_OVR = 1'b0;
`endif

   spislave dut (
      .clkin(clkin), .rst(rst), .cpol(cpol), .cpha(cpha), .cspol(cspol),
      .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy), .overrun(overrun)
   );

   always #5 clkin = ~clkin;

   // Record each received byte and any output-enable activity.
   always @(negedge clkin) begin
      if (rx_valid) begin
         rx_hist[vcnt % 16] = rx_data;
         vcnt = vcnt + 1;
      end
      if (miso_oe) oe_cnt = oe_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clkin);
   endtask

   task automatic half();
      tick(5);
   endtask

   // Half bit-time wait that records how many clkin edges rx_valid took.
   task automatic wait_lat();
      for (int k = 1; k <= 5; k++) begin
         @(negedge clkin);
         if (rx_valid && lat < 0) lat = k;
      end
   endtask

   // SPI master: shifts nb bits of mo out MSB first, returns bits read.
   task automatic xfer_bits(input logic [7:0] mo, input int nb, output logic [7:0] mi);
      logic [7:0] r;
      r   = 8'h00;
      lat = -1;
      for (int i = 7; i > 7 - nb; i--) begin
         if (!cpha) begin
            mosi = mo[i]; half();
            sclk = ~cpol; r[i] = miso;
            if (i == 0) wait_lat(); else half();
            sclk = cpol;
         end else begin
            sclk = ~cpol; mosi = mo[i]; half();
            sclk = cpol; r[i] = miso;
            if (i == 0) wait_lat(); else half();
         end
      end
      half();
      mi = r;
   endtask

   task automatic one_frame(input logic [7:0] b, output logic [7:0] mi);
      cs = ~cspol; half();
      xfer_bits(b, 8, mi);
      cs = cspol; tick(5);
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(3);
      chk_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso got %b exp 0", miso); else pass_cnt++;
      chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL reset_oe got %b exp 0", miso_oe); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
      chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rxv got %b exp 0", rx_valid); else pass_cnt++;
      chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ovr got %b exp 0", overrun); else pass_cnt++;
      chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rxd got %h exp 00", rx_data); else pass_cnt++;
      rst = 1'b0; tick(4);
   endtask

   task automatic test_mode0();
      int v0;
      tx_data = 8'hA5; tx_load = 1'b1; tick(1); tx_load = 1'b0;
      v0 = vcnt;
      cs = 1'b0; half();
      chk_cnt++; if (busy !== 1'b1) $display("FAIL m0_busy got %b exp 1", busy); else pass_cnt++;
      chk_cnt++; if (miso_oe !== 1'b1) $display("FAIL m0_oe got %b exp 1", miso_oe); else pass_cnt++;
      chk_cnt++; if (miso !== 1'b1) $display("FAIL m0_first_bit got %b exp 1", miso); else pass_cnt++;
      xfer_bits(8'h3C, 8, m1);
      chk_cnt++; if (lat !== 3) $display("FAIL m0_latency got %0d exp 3", lat); else pass_cnt++;
      chk_cnt++; if (m1 !== 8'hA5) $display("FAIL m0_miso_byte got %h exp a5", m1); else pass_cnt++;
      tick(3);
      chk_cnt++; if (rx_data !== 8'h3C) $display("FAIL m0_rxd got %h exp 3c", rx_data); else pass_cnt++;
      chk_cnt++; if (vcnt - v0 !== 1) $display("FAIL m0_pulses got %0d exp 1", vcnt - v0); else pass_cnt++;
      cs = 1'b1; tick(5);
      chk_cnt++; if (busy !== 1'b0) $display("FAIL m0_idle_busy got %b exp 0", busy); else pass_cnt++;
      chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL m0_idle_oe got %b exp 0", miso_oe); else pass_cnt++;
      chk_cnt++; if (miso !== 1'b0) $display("FAIL m0_idle_miso got %b exp 0", miso); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int v0;
      cpol = 1'b1; sclk = 1'b1; cpha = 1'b1; tick(5);
      v0 = vcnt;
      cs = 1'b0; half();
      fork
         xfer_bits(8'h81, 8, m1);
         begin
            tick(20); tx_data = 8'h55; tx_load = 1'b1; tick(1); tx_load = 1'b0;
         end
      join
      xfer_bits(8'h7E, 8, m2);
      tick(3);
      chk_cnt++; if (m1 !== 8'hA5) $display("FAIL b2b_miso1 got %h exp a5", m1); else pass_cnt++;
      chk_cnt++; if (m2 !== 8'h55) $display("FAIL b2b_miso2 got %h exp 55", m2); else pass_cnt++;
      chk_cnt++; if (vcnt - v0 !== 2) $display("FAIL b2b_pulses got %0d exp 2", vcnt - v0); else pass_cnt++;
      chk_cnt++; if (rx_hist[v0 % 16] !== 8'h81) $display("FAIL b2b_rx1 got %h exp 81", rx_hist[v0 % 16]); else pass_cnt++;
      chk_cnt++; if (rx_hist[(v0 + 1) % 16] !== 8'h7E) $display("FAIL b2b_rx2 got %h exp 7e", rx_hist[(v0 + 1) % 16]); else pass_cnt++;
      chk_cnt++; if (rx_data !== 8'h7E) $display("FAIL b2b_rxd got %h exp 7e", rx_data); else pass_cnt++;
      cs = 1'b1; tick(5);
   endtask

   task automatic test_abort();
      int v0;
      cpol = 1'b0; sclk = 1'b0; cpha = 1'b0; tick(5);
      v0 = vcnt;
      cs = 1'b0; half();
      xfer_bits(8'hFF, 5, m1);
      cs = 1'b1; tick(10);
      chk_cnt++; if (vcnt - v0 !== 0) $display("FAIL abort_pulses got %0d exp 0", vcnt - v0); else pass_cnt++;
      chk_cnt++; if (rx_data !== 8'h7E) $display("FAIL abort_rxd got %h exp 7e", rx_data); else pass_cnt++;
      one_frame(8'hC3, m1);
      chk_cnt++; if (rx_data !== 8'hC3) $display("FAIL abort_next_rxd got %h exp c3", rx_data); else pass_cnt++;
      chk_cnt++; if (vcnt - v0 !== 1) $display("FAIL abort_next_pulses got %0d exp 1", vcnt - v0); else pass_cnt++;
      chk_cnt++; if (m1 !== 8'h55) $display("FAIL abort_next_miso got %h exp 55", m1); else pass_cnt++;
   endtask

   task automatic test_rst_mid();
      int v0;
      v0 = vcnt;
      cs = 1'b0; half();
      xfer_bits(8'hF0, 4, m1);
      rst = 1'b1; tick(1);
      chk_cnt++; if (miso !== 1'b0) $display("FAIL rmid_miso got %b exp 0", miso); else pass_cnt++;
      chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL rmid_oe got %b exp 0", miso_oe); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else pass_cnt++;
      chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL rmid_rxv got %b exp 0", rx_valid); else pass_cnt++;
      chk_cnt++; if (overrun !== 1'b0) $display("FAIL rmid_ovr got %b exp 0", overrun); else pass_cnt++;
      chk_cnt++; if (rx_data !== 8'h00) $display("FAIL rmid_rxd got %h exp 00", rx_data); else pass_cnt++;
      rst = 1'b0;
      xfer_bits(8'h0F, 4, m1);
      tick(5);
      chk_cnt++; if (vcnt - v0 !== 0) $display("FAIL rmid_pulses got %0d exp 0", vcnt - v0); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rmid_no_restart got %b exp 0", busy); else pass_cnt++;
      cs = 1'b1; tick(5);
   endtask

   task automatic test_idle_sclk();
      int v0, o0;
      v0 = vcnt; o0 = oe_cnt;
      for (int i = 0; i < 16; i++) begin
         sclk = ~sclk; mosi = i[0]; tick(5);
      end
      chk_cnt++; if (vcnt - v0 !== 0) $display("FAIL idle_pulses got %0d exp 0", vcnt - v0); else pass_cnt++;
      chk_cnt++; if (oe_cnt - o0 !== 0) $display("FAIL idle_oe got %0d exp 0", oe_cnt - o0); else pass_cnt++;
   endtask

   task automatic test_overrun();
      cs = 1'b1; rst = 1'b1; tick(2); rst = 1'b0; tick(4);
      one_frame(8'h11, m1);
      chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_first got %b exp 0", overrun); else pass_cnt++;
      rx_ack = 1'b1; tick(1); rx_ack = 1'b0;
      one_frame(8'h22, m1);
      chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_acked got %b exp 0", overrun); else pass_cnt++;
      one_frame(8'h33, m1);
      chk_cnt++; if (overrun !== EXP_OVR) $display("FAIL ovr_set got %b exp %b", overrun, EXP_OVR); else pass_cnt++;
      tick(20);
      chk_cnt++; if (overrun !== EXP_OVR) $display("FAIL ovr_sticky got %b exp %b", overrun, EXP_OVR); else pass_cnt++;
      rst = 1'b1; tick(1);
      chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_rst got %b exp 0", overrun); else pass_cnt++;
      rst = 1'b0; tick(2);
   endtask

   initial begin
      rst = 1'b1; cpol = 1'b0; cpha = 1'b0; cspol = 1'b1;
      sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
      tx_data = 8'h00; tx_load = 1'b0; rx_ack = 1'b0;
      test_reset();
      test_mode0();
      test_back_to_back();
      test_abort();
      test_rst_mid();
      test_idle_sclk();
      test_overrun();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/spislave.md
SPISLAVE -- requirements
Module: spislave

Interface
REQ-001 Parameter: none. Frame length fixed at 8 bits, MSB first.
REQ-002 clkin  input  1  system clock; all logic clocked on rising edge; one clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cpol  input  1  SPI clock idle level.
REQ-005 cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-006 cspol  input  1  cs idle level; active level = ~cspol.
REQ-007 sclk, mosi, cs  input  1 each  asynchronous SPI pins from the external master.
REQ-008 miso  output  1  serial data to master; miso_oe  output  1  high while cs is active.
REQ-009 tx_data  input  8  next byte to transmit; tx_load  input  1  one-cycle strobe that captures tx_data into tx_buf.
REQ-010 rx_data  output  8  last complete received byte; rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 rx_ack  input  1  consumer acknowledges rx_data; busy  output  1  high in state ACTIVE.
REQ-012 overrun  output  1  sticky error flag (see Configuration).

Function
REQ-013 sclk, mosi and cs each pass through a 2-flop synchronizer; edges are detected on synchronized values only.
REQ-014 Supported sclk frequency: at most clkin/8; higher rates are out of scope.
REQ-015 Leading edge = sclk transition cpol -> ~cpol; trailing edge = ~cpol -> cpol.
REQ-016 States: IDLE, ACTIVE. IDLE -> ACTIVE on synchronized cs becoming ~cspol; ACTIVE -> IDLE on cs returning to cspol.
REQ-017 On IDLE -> ACTIVE: shift register loads tx_buf, bit counter clears to 0, miso drives tx_buf[7] in the same cycle.
REQ-018 Sample edge (leading if cpha=0, trailing if cpha=1): shift synchronized mosi into the LSB of the receive shifter; increment bit counter.
REQ-019 Shift edge (the other edge): advance the transmit shifter; miso drives the next bit. For cpha=1, the first leading edge drives bit 7 without advancing.
REQ-020 On the 8th sample edge: rx_data <= received byte, rx_valid pulses, bit counter wraps to 0, transmit shifter reloads tx_buf. Back-to-back frames within one cs assertion are supported.
REQ-021 Latency: rx_valid asserts on the 3rd clkin rising edge after the 8th sampling sclk edge at the pin.
REQ-022 tx_load: accepted in any state. The value is used at the next frame start (REQ-017/020). If tx_buf is not reloaded, the next frame retransmits the same byte.
REQ-023 tx_load coinciding with a frame-start reload: the shifter takes the new tx_data.
REQ-024 cs deasserted mid-frame: the partial frame is discarded, no rx_valid, rx_data is unchanged, and the counter clears.
REQ-025 sclk edges while cs is inactive are ignored. miso is 0 and miso_oe is 0 in IDLE.
REQ-026 rx_ack clears the pending flag. rx_valid and rx_ack in the same cycle: pending remains set.

Reset
REQ-027 rst forces state IDLE and sets miso=0, miso_oe=0, busy=0, rx_valid=0, overrun=0, rx_data=0x00, tx_buf=0x00, counter=0, and synchronizers to idle levels (sclk=cpol, cs=cspol).
REQ-028 rst asserted mid-frame aborts the frame with no rx_valid. The first frame after reset requires a fresh cs assertion.

Configuration
REQ-029 Macro SPISLAVE_OVERRUN_EN.
- Defined: rx_valid while the pending flag is set sets overrun. overrun is sticky until rst. rx_data is still overwritten.
- Undefined: overrun is tied to 0, and the pending logic is removed.

Verification
REQ-030 cpol=0, cpha=0, cspol=1, tx_buf=0xA5, master sends 0x3C -> miso returns 0xA5, rx_data=0x3C, exactly one rx_valid pulse.
REQ-031 cpol=1, cpha=1, two frames in one cs assertion, master sends 0x81 then 0x7E, tx_load 0x55 during frame 1 -> rx_valid twice, rx_data 0x81 then 0x7E, master reads 0xA5 then 0x55.
REQ-032 cs deasserted after 5 sclk cycles -> no rx_valid, rx_data unchanged, next full frame 0xC3 received correctly.
REQ-033 SPISLAVE_OVERRUN_EN defined, two frames without rx_ack -> overrun=1 after the second rx_valid, stays 1 until rst; with the macro undefined, overrun stays 0.
REQ-034 rst pulsed during bit 4 of a frame -> all outputs at REQ-027 values the next cycle, no rx_valid.
REQ-035 sclk toggled 8 times with cs inactive -> no rx_valid, miso_oe=0 throughout.
